// File: rtl/hp_mul_seq_if.sv
// Operand/result handshake bundle for the sequential binary16 multiplier.
// The master drives operands and out_ready; the slave (the multiplier) drives the rest.
interface hp_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic        a_sign;
  logic [6:0]  a_exp;
  logic [10:0] a_sig;
  logic [5:0]  a_class;
  logic        b_sign;
  logic [6:0]  b_exp;
  logic [10:0] b_sig;
  logic [5:0]  b_class;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  modport master (
    output in_valid, a_sign, a_exp, a_sig, a_class, b_sign, b_exp, b_sig, b_class, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a_sign, a_exp, a_sig, a_class, b_sign, b_exp, b_sig, b_class, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/hp_mul_seq.sv
// Iterative binary16 multiplier with round-to-nearest-even.
// Operands arrive pre-classified and unpacked; specials resolve in one cycle,
// finite products take 11 shift-add cycles, one normalise and one round cycle.
module hp_mul_seq #(
  parameter logic [15:0] DEFAULT_NAN = 16'h7E00,
  parameter bit          FTZ         = 1'b0
) (
  input logic         clk,
  input logic         rst,
  hp_mul_seq_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StMul, StNorm, StRnd, StDone} stateE;

  stateE              stateQ, stateD;
  logic               signQ;
  logic [10:0]        aSigQ, bSigQ;
  logic signed [7:0]  expQ;
  logic [21:0]        prodQ;
  logic [3:0]         cntQ;
  logic [10:0]        manQ;
  logic               guardQ, stickyQ, tinyQ;
  logic signed [7:0]  bexpQ;
  logic [15:0]        resultQ;
  logic [3:0]         flagsQ;

  logic               inSign, aFinite, bFinite, isSpecial;
  logic signed [7:0]  expSum;
  logic [15:0]        specResult;
  logic [3:0]         specFlags;

  logic [21:0]        normVec;
  logic signed [7:0]  normExp, shAmt, normBexp;
  logic [4:0]         shCap;
  logic [43:0]        shExt;
  logic [10:0]        normMan;
  logic               normGuard, normSticky, normTiny;

  logic               roundUp, inexact;
  logic [11:0]        manR;
  logic [9:0]         rMan;
  logic signed [7:0]  rExp;
  logic [15:0]        rndResult;
  logic [3:0]         rndFlags;

  // Classify the incoming pair and resolve every non-finite combination.
  always_comb begin
    inSign     = bus.a_sign ^ bus.b_sign;
    aFinite    = |bus.a_class[1:0];
    bFinite    = |bus.b_class[1:0];
    isSpecial  = ~(aFinite & bFinite);
    expSum     = $signed({bus.a_exp[6], bus.a_exp}) + $signed({bus.b_exp[6], bus.b_exp});
    specResult = {inSign, 15'h0000};
    specFlags  = 4'h0;
    if (bus.a_class[5] | bus.b_class[5]) begin
      specResult = DEFAULT_NAN;
      specFlags  = 4'b1000;
    end else if (bus.a_class[4] | bus.b_class[4]) begin
      specResult = DEFAULT_NAN;
    end else if ((bus.a_class[3] & bus.b_class[2]) | (bus.a_class[2] & bus.b_class[3])) begin
      specResult = DEFAULT_NAN;
      specFlags  = 4'b1000;
    end else if (bus.a_class[3] | bus.b_class[3]) begin
      specResult = {inSign, 15'h7C00};
    end
  end

  // Normalise the raw product; tiny results are denormalised into guard/sticky.
  always_comb begin
    normVec    = prodQ[21] ? prodQ : {prodQ[20:0], 1'b0};
    normExp    = prodQ[21] ? expQ + 8'sd16 : expQ + 8'sd15;
    shAmt      = 8'sd1 - normExp;
    shCap      = 5'd0;
    shExt      = '0;
    normMan    = normVec[21:11];
    normGuard  = normVec[10];
    normSticky = |normVec[9:0];
    normBexp   = normExp;
    normTiny   = 1'b0;
    if (normExp <= 8'sd0) begin
      // 23 places already clears mantissa and guard, so larger shifts saturate there.
      shCap      = (shAmt > 8'sd23) ? 5'd23 : shAmt[4:0];
      shExt      = {normVec, 22'b0} >> shCap;
      normMan    = shExt[43:33];
      normGuard  = shExt[32];
      normSticky = |shExt[31:0];
      normBexp   = 8'sd0;
      normTiny   = 1'b1;
    end
  end

  // Round to nearest even and pack, handling overflow and flush-to-zero.
  always_comb begin
    roundUp = guardQ & (stickyQ | manQ[0]);
    inexact = guardQ | stickyQ;
    manR    = {1'b0, manQ} + {11'b0, roundUp};
    if (manR[11]) begin
      rMan = manR[10:1];
      rExp = bexpQ + 8'sd1;
    end else begin
      rMan = manR[9:0];
      // A subnormal that rounds up into bit 10 becomes the smallest normal.
      rExp = (bexpQ == 8'sd0 && manR[10]) ? 8'sd1 : bexpQ;
    end
    rndResult = {signQ, rExp[4:0], rMan};
    rndFlags  = {2'b00, tinyQ & inexact, inexact};
    if (rExp >= 8'sd31) begin
      rndResult = {signQ, 15'h7C00};
      rndFlags  = 4'b0101;
    end else if (FTZ && rExp == 8'sd0) begin
      rndResult = {signQ, 15'h0000};
      rndFlags  = 4'b0011;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: if (bus.in_valid) stateD = isSpecial ? StDone : StMul;
      StMul:  if (cntQ == 4'd10) stateD = StNorm;
      StNorm: stateD = StRnd;
      StRnd:  stateD = StDone;
      StDone: if (bus.out_ready) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Datapath registers, advanced according to the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signQ   <= 1'b0;
      aSigQ   <= '0;
      bSigQ   <= '0;
      expQ    <= '0;
      prodQ   <= '0;
      cntQ    <= '0;
      manQ    <= '0;
      guardQ  <= 1'b0;
      stickyQ <= 1'b0;
      tinyQ   <= 1'b0;
      bexpQ   <= '0;
      resultQ <= '0;
      flagsQ  <= '0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (bus.in_valid) begin
            signQ <= inSign;
            aSigQ <= bus.a_sig;
            bSigQ <= bus.b_sig;
            expQ  <= expSum;
            prodQ <= '0;
            cntQ  <= '0;
            if (isSpecial) begin
              resultQ <= specResult;
              flagsQ  <= specFlags;
            end
          end
        end
        StMul: begin
          // One multiplier bit per cycle, LSB first.
          if (bSigQ[cntQ]) prodQ <= prodQ + ({11'b0, aSigQ} << cntQ);
          cntQ <= cntQ + 4'd1;
        end
        StNorm: begin
          manQ    <= normMan;
          guardQ  <= normGuard;
          stickyQ <= normSticky;
          bexpQ   <= normBexp;
          tinyQ   <= normTiny;
        end
        StRnd: begin
          resultQ <= rndResult;
          flagsQ  <= rndFlags;
        end
        default: ;
      endcase
    end
  end

  // Handshake and result outputs.
  always_comb begin
    bus.in_ready  = (stateQ == StIdle);
    bus.out_valid = (stateQ == StDone);
    bus.result    = resultQ;
    bus.flags     = flagsQ;
  end

endmodule

// File: tb/tb_hp_mul_seq.sv
// Self-checking bench for hp_mul_seq: expected results are queued when an
// operation is launched and popped when the multiplier presents its output.
module tb_hp_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] expRes[$];
  logic [3:0]  expFlg[$];
  int          expLat[$];

  hp_mul_seq_if bus ();

  hp_mul_seq #(
    .DEFAULT_NAN(16'h7E00),
    .FTZ        (1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Unpack a binary16 value the way the upstream classifier does.
  task automatic hp_class(input logic [15:0] h, output logic s, output logic [6:0] e,
                          output logic [10:0] sig, output logic [5:0] cls);
    int p;
    int ex;
    s   = h[15];
    e   = '0;
    sig = '0;
    cls = '0;
    if (h[14:10] == 5'd31) begin
      if (h[9:0] == 10'd0) cls = 6'b001000;
      else if (h[9])       cls = 6'b010000;
      else                 cls = 6'b100000;
    end else if (h[14:10] == 5'd0) begin
      if (h[9:0] == 10'd0) begin
        cls = 6'b000100;
      end else begin
        p = 0;
        for (int i = 0; i < 10; i++) if (h[i]) p = i;
        ex  = p - 24;
        e   = 7'(ex);
        sig = 11'({1'b0, h[9:0]} << (10 - p));
        cls = 6'b000010;
      end
    end else begin
      ex  = int'(h[14:10]) - 15;
      e   = 7'(ex);
      sig = {1'b1, h[9:0]};
      cls = 6'b000001;
    end
  endtask

  task automatic drive_ops(input logic [15:0] a, input logic [15:0] b);
    hp_class(a, bus.a_sign, bus.a_exp, bus.a_sig, bus.a_class);
    hp_class(b, bus.b_sign, bus.b_exp, bus.b_sig, bus.b_class);
  endtask

  // Launch one operation, optionally wiggle inputs while busy, then check the result.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic [3:0] flg, input int lat,
                        input bit junk);
    int          w;
    int          n;
    logic [15:0] r;
    logic [3:0]  f;
    int          l;
    expRes.push_back(res);
    expFlg.push_back(flg);
    expLat.push_back(lat);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    drive_ops(a, b);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = junk;
    drive_ops(16'($urandom), 16'($urandom));
    n = 1;
    while (!bus.out_valid && n < 40) begin
      if (n == 5) bus.in_valid = 1'b0;
      @(posedge clk); #1; n++;
    end
    bus.in_valid = 1'b0;
    r = expRes.pop_front();
    f = expFlg.pop_front();
    l = expLat.pop_front();
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL %s timeout: out_valid got %b expected 1", name, bus.out_valid);
    end else begin
      if (bus.result !== r) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", name, bus.result, r);
      end
      checks++;
      if (bus.flags !== f) begin
        errors++;
        $display("FAIL %s flags: got %b expected %b", name, bus.flags, f);
      end
      checks++;
      if (n !== l) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", name, n, l);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s in_ready_busy: got %b expected 0", name, bus.in_ready);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b expected 0/1", name,
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.result !== 16'h0000) begin
      errors++; $display("FAIL reset result: got %h expected 0000", bus.result);
    end
    checks++;
    if (bus.flags !== 4'h0) begin
      errors++; $display("FAIL reset flags: got %b expected 0000", bus.flags);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_finite();
    run_op("one_x_one",     16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 14, 1'b0);
    run_op("inexact",       16'h3C01, 16'h3C01, 16'h3C02, 4'b0001, 14, 1'b0);
    run_op("two_x_three",   16'h4000, 16'h4200, 16'h4600, 4'b0000, 14, 1'b0);
    run_op("neg_sign",      16'hC000, 16'h3C00, 16'hC000, 4'b0000, 14, 1'b0);
    run_op("overflow",      16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101, 14, 1'b0);
    run_op("sub_tie_even",  16'h0001, 16'h3800, 16'h0000, 4'b0011, 14, 1'b0);
    run_op("sub_exact",     16'h0001, 16'h4000, 16'h0002, 4'b0000, 14, 1'b0);
    run_op("tiny_exact",    16'h0400, 16'h3800, 16'h0200, 4'b0000, 14, 1'b0);
    run_op("sub_to_normal", 16'h03FF, 16'h3C01, 16'h0400, 4'b0011, 14, 1'b0);
  endtask

  task automatic test_special();
    run_op("inf_x_zero",  16'h7C00, 16'h8000, 16'h7E00, 4'b1000, 1, 1'b0);
    run_op("snan",        16'h7C01, 16'h3C00, 16'h7E00, 4'b1000, 1, 1'b0);
    run_op("qnan",        16'h7E00, 16'h3C00, 16'h7E00, 4'b0000, 1, 1'b0);
    run_op("neg_inf",     16'hFC00, 16'h3C00, 16'hFC00, 4'b0000, 1, 1'b0);
    run_op("zero_finite", 16'h8000, 16'h4000, 16'h8000, 4'b0000, 1, 1'b0);
  endtask

  task automatic test_busy_ignore();
    run_op("busy_junk_a", 16'h4000, 16'h4200, 16'h4600, 4'b0000, 14, 1'b1);
    run_op("busy_junk_b", 16'h3C01, 16'h3C01, 16'h3C02, 4'b0001, 14, 1'b1);
  endtask

  task automatic test_backpressure();
    int          n;
    logic [15:0] r;
    logic [3:0]  f;
    expRes.push_back(16'h3C02);
    expFlg.push_back(4'b0001);
    bus.out_ready = 1'b0;
    drive_ops(16'h3C01, 16'h3C01);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    r = expRes.pop_front();
    f = expFlg.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== r || bus.flags !== f || bus.in_ready !== 1'b0)
      begin
        errors++;
        $display("FAIL stall_%0d: got v=%b res=%h flg=%b rdy=%b expected 1/%h/%b/0", i,
                 bus.out_valid, bus.result, bus.flags, bus.in_ready, r, f);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got out_valid=%b in_ready=%b expected 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    drive_ops(16'h3C00, 16'h3C00);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got in_ready=%b out_valid=%b expected 1/0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d valid cycles in_ready=%b expected 0/1", seen,
               bus.in_ready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive_ops(16'h0000, 16'h0000);
    test_reset();
    test_finite();
    test_special();
    test_busy_ignore();
    test_backpressure();
    test_reset_mid();
    run_op("after_reset", 16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 14, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
